// File: rtl/elevator_pkg.sv
// Shared constants and types for the elevator call panel.
// Optional feature macro used by the top level: ELEVATOR_CALL_CANCEL_EN.
package elevator_pkg;

  localparam int NUM_FLOORS      = 5;
  localparam int FLOOR_W         = 3;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int CNT_W           = 3;
  localparam int CANCEL_CYCLES   = 16;

  // Per-floor call state: IDLE (no call registered) or PENDING (lamp lit).
  typedef enum logic {
    CALL_IDLE    = 1'b0,
    CALL_PENDING = 1'b1
  } call_state_t;

endpackage

// File: rtl/button_debounce.sv
// One mechanical button: 2-flop synchroniser, stability counter, and
// rising-edge detect on the debounced level.
// The level flips on the edge after the counter has reached DEBOUNCE_CYCLES,
// and press is a combinational one-cycle strobe on the following cycle, so a
// raw level sampled at edge k shows up as press during the cycle after edge
// k+DEBOUNCE_CYCLES+2.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Synchroniser, debounce state and edge-detect history.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      prev_q  <= level_q;
      cnt_q   <= cnt_d;
    end
  end

  // Count consecutive cycles of disagreement; any agreement restarts the count.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign level_o = level_q;
  assign press_o = level_q & ~prev_q;

endmodule

// File: rtl/elevator_call_panel.sv
// Elevator call panel: debounces per-floor call buttons, pulses a request
// toward the controller for each new call and keeps the call lamp lit until
// the car opens its door at that floor.
// Optional feature: define ELEVATOR_CALL_CANCEL_EN to let a long hold of a
// pending floor's button cancel the call (adds CANCEL_CYCLES and `cancel`).
//
// Handshake: `buttons` is a fire-and-forget valid strobe, one cycle per
// accepted call; there is no ready, the controller must sample every cycle.
module elevator_call_panel
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS      = elevator_pkg::NUM_FLOORS,
  parameter int FLOOR_W         = elevator_pkg::FLOOR_W,
  parameter int DEBOUNCE_CYCLES = elevator_pkg::DEBOUNCE_CYCLES,
`ifdef ELEVATOR_CALL_CANCEL_EN
  parameter int CANCEL_CYCLES   = elevator_pkg::CANCEL_CYCLES,
`endif
  parameter int CNT_W           = elevator_pkg::CNT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] raw_buttons,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  door_open,
`ifdef ELEVATOR_CALL_CANCEL_EN
  output logic [NUM_FLOORS-1:0] cancel,
`endif
  output logic [NUM_FLOORS-1:0] buttons,
  output logic [NUM_FLOORS-1:0] lamps,
  output logic [CNT_W-1:0]      pending_count
);

  logic [NUM_FLOORS-1:0] level;
  logic [NUM_FLOORS-1:0] press;
  logic [NUM_FLOORS-1:0] service;

  call_state_t           state_q [NUM_FLOORS];
  call_state_t           state_d [NUM_FLOORS];
  logic [NUM_FLOORS-1:0] buttons_q, buttons_d;

  // One debouncer per floor button.
  for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_deb
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk     (clk),
      .reset   (reset),
      .raw_i   (raw_buttons[g]),
      .level_o (level[g]),
      .press_o (press[g])
    );
  end

  // A floor is serviced while the door is open there; out-of-range floors
  // never match any index.
  always_comb begin
    service = '0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      service[f] = door_open && (current_floor == FLOOR_W'(f));
    end
  end

`ifdef ELEVATOR_CALL_CANCEL_EN
  localparam int HW = $clog2(CANCEL_CYCLES + 1);

  logic [HW-1:0]         hold_cnt_q [NUM_FLOORS];
  logic [HW-1:0]         hold_cnt_d [NUM_FLOORS];
  logic [NUM_FLOORS-1:0] hold_blk_q, hold_blk_d;
  logic [NUM_FLOORS-1:0] cancel_q, cancel_d;

  // Hold-to-cancel bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int f = 0; f < NUM_FLOORS; f++) hold_cnt_q[f] <= '0;
      hold_blk_q <= '0;
      cancel_q   <= '0;
    end else begin
      for (int f = 0; f < NUM_FLOORS; f++) hold_cnt_q[f] <= hold_cnt_d[f];
      hold_blk_q <= hold_blk_d;
      cancel_q   <= cancel_d;
    end
  end

  assign cancel = cancel_q;
`endif

  // Per-floor call FSM state and the registered request strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int f = 0; f < NUM_FLOORS; f++) state_q[f] <= CALL_IDLE;
      buttons_q <= '0;
    end else begin
      for (int f = 0; f < NUM_FLOORS; f++) state_q[f] <= state_d[f];
      buttons_q <= buttons_d;
    end
  end

  // Next state: service always wins (the car is already there), a press in
  // IDLE registers a call and pulses the request, a press in PENDING is a no-op.
  always_comb begin
    buttons_d = '0;
    for (int f = 0; f < NUM_FLOORS; f++) state_d[f] = state_q[f];
`ifdef ELEVATOR_CALL_CANCEL_EN
    cancel_d   = '0;
    hold_blk_d = hold_blk_q;
    for (int f = 0; f < NUM_FLOORS; f++) hold_cnt_d[f] = '0;
`endif
    for (int f = 0; f < NUM_FLOORS; f++) begin
      if (service[f]) begin
        state_d[f] = CALL_IDLE;
      end else begin
        case (state_q[f])
          CALL_IDLE: begin
            if (press[f]) begin
              state_d[f]   = CALL_PENDING;
              buttons_d[f] = 1'b1;
            end
          end
          CALL_PENDING: begin
`ifdef ELEVATOR_CALL_CANCEL_EN
            // Only one cancel per hold: the block clears once released.
            if (level[f] && !hold_blk_q[f]) begin
              if (hold_cnt_q[f] == HW'(CANCEL_CYCLES - 1)) begin
                state_d[f]    = CALL_IDLE;
                cancel_d[f]   = 1'b1;
                hold_blk_d[f] = 1'b1;
              end else begin
                hold_cnt_d[f] = hold_cnt_q[f] + 1'b1;
              end
            end
`endif
          end
          default: state_d[f] = CALL_IDLE;
        endcase
      end
`ifdef ELEVATOR_CALL_CANCEL_EN
      if (!level[f]) hold_blk_d[f] = 1'b0;
`endif
    end
  end

  // Lamps mirror the registered PENDING state; the count follows them directly.
  always_comb begin
    lamps         = '0;
    pending_count = '0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      lamps[f]      = (state_q[f] == CALL_PENDING);
      pending_count = pending_count + CNT_W'(lamps[f]);
    end
  end

  assign buttons = buttons_q;

`ifndef ELEVATOR_CALL_CANCEL_EN
  // Debounced level is only needed for hold-to-cancel.
  logic unused_level;
  assign unused_level = ^level;
`endif

endmodule

// File: tb/tb_elevator_call_panel.sv
// Directed bench for elevator_call_panel with hand-computed expectations.
module tb_elevator_call_panel;

  logic       clk;
  logic       reset;
  logic [4:0] raw_buttons;
  logic [2:0] current_floor;
  logic       door_open;
  logic [4:0] buttons;
  logic [4:0] lamps;
  logic [2:0] pending_count;
`ifdef ELEVATOR_CALL_CANCEL_EN
  logic [4:0] cancel;
`endif

  int checks = 0;
  int passes = 0;

  elevator_call_panel dut (
    .clk           (clk),
    .reset         (reset),
    .raw_buttons   (raw_buttons),
    .current_floor (current_floor),
    .door_open     (door_open),
`ifdef ELEVATOR_CALL_CANCEL_EN
    .cancel        (cancel),
`endif
    .buttons       (buttons),
    .lamps         (lamps),
    .pending_count (pending_count)
  );

  // Clock and initial input levels.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; raw_buttons = '0; current_floor = '0; door_open = 1'b0;
    repeat (3) tick();
    checks++; if (buttons !== 5'b0) $display("FAIL reset_buttons got=%b exp=%b", buttons, 5'b0); else passes++;
    checks++; if (lamps !== 5'b0) $display("FAIL reset_lamps got=%b exp=%b", lamps, 5'b0); else passes++;
    checks++; if (pending_count !== 3'd0) $display("FAIL reset_count got=%0d exp=0", pending_count); else passes++;
    reset = 1'b0;
  endtask

  // Raw high sampled at edge k; request pulse visible only after edge k+7.
  task automatic test_single_press();
    raw_buttons = 5'b00100;
    tick(); // edge k
    for (int e = 1; e <= 10; e++) begin
      tick();
      checks++;
      if (buttons !== ((e == 7) ? 5'b00100 : 5'b00000))
        $display("FAIL press_latency edge=%0d got=%b exp=%b", e, buttons, (e == 7) ? 5'b00100 : 5'b00000);
      else passes++;
    end
    checks++; if (lamps !== 5'b00100) $display("FAIL press_lamp got=%b exp=%b", lamps, 5'b00100); else passes++;
    checks++; if (pending_count !== 3'd1) $display("FAIL press_count got=%0d exp=1", pending_count); else passes++;
    // Release must produce no output.
    raw_buttons = '0;
    begin
      int pulses = 0;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (buttons != 5'b0) pulses++;
      end
      checks++; if (pulses !== 0) $display("FAIL release_quiet got=%0d exp=0", pulses); else passes++;
    end
    checks++; if (lamps !== 5'b00100) $display("FAIL release_lamp got=%b exp=%b", lamps, 5'b00100); else passes++;
  endtask

  task automatic test_glitch();
    int pulses = 0;
    logic [3:0] pat = 4'b0101; // applied LSB first: 1,0,1,0
    for (int i = 0; i < 4; i++) begin
      raw_buttons = {3'b000, pat[i], 1'b0};
      tick();
      if (buttons != 5'b0) pulses++;
    end
    raw_buttons = '0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (buttons != 5'b0) pulses++;
    end
    checks++; if (pulses !== 0) $display("FAIL glitch_pulses got=%0d exp=0", pulses); else passes++;
    checks++; if (lamps !== 5'b00100) $display("FAIL glitch_lamps got=%b exp=%b", lamps, 5'b00100); else passes++;
  endtask

  task automatic test_repress_and_service();
    int pulses;
    // First press of floor 3.
    pulses = 0;
    raw_buttons = 5'b01000;
    for (int i = 0; i < 10; i++) begin tick(); if (buttons == 5'b01000) pulses++; else if (buttons != 5'b0) pulses += 10; end
    raw_buttons = '0;
    for (int i = 0; i < 10; i++) begin tick(); if (buttons != 5'b0) pulses += 10; end
    checks++; if (pulses !== 1) $display("FAIL first_press_pulses got=%0d exp=1", pulses); else passes++;
    checks++; if (lamps !== 5'b01100) $display("FAIL first_press_lamps got=%b exp=%b", lamps, 5'b01100); else passes++;
    checks++; if (pending_count !== 3'd2) $display("FAIL first_press_count got=%0d exp=2", pending_count); else passes++;
    // Re-press while pending: ignored.
    pulses = 0;
    raw_buttons = 5'b01000;
    for (int i = 0; i < 10; i++) begin tick(); if (buttons != 5'b0) pulses++; end
    raw_buttons = '0;
    for (int i = 0; i < 10; i++) begin tick(); if (buttons != 5'b0) pulses++; end
    checks++; if (pulses !== 0) $display("FAIL repress_pulses got=%0d exp=0", pulses); else passes++;
    // One cycle of service at floor 3 clears its lamp on that edge.
    current_floor = 3'd3; door_open = 1'b1;
    tick();
    door_open = 1'b0;
    checks++; if (lamps !== 5'b00100) $display("FAIL service3_lamps got=%b exp=%b", lamps, 5'b00100); else passes++;
    checks++; if (pending_count !== 3'd1) $display("FAIL service3_count got=%0d exp=1", pending_count); else passes++;
  endtask

  task automatic test_press_during_service();
    int pulses = 0;
    current_floor = 3'd2; door_open = 1'b1;
    raw_buttons = 5'b00100;
    for (int i = 0; i < 12; i++) begin tick(); if (buttons != 5'b0) pulses++; end
    raw_buttons = '0;
    for (int i = 0; i < 10; i++) begin tick(); if (buttons != 5'b0) pulses++; end
    door_open = 1'b0;
    checks++; if (pulses !== 0) $display("FAIL service_press_pulses got=%0d exp=0", pulses); else passes++;
    checks++; if (lamps !== 5'b00000) $display("FAIL service_press_lamps got=%b exp=%b", lamps, 5'b00000); else passes++;
    checks++; if (pending_count !== 3'd0) $display("FAIL service_press_count got=%0d exp=0", pending_count); else passes++;
  endtask

  // Buttons held through a reset that lands mid-debounce.
  task automatic test_held_through_reset();
    raw_buttons = 5'b10001;
    repeat (3) tick();          // partial debounce progress
    reset = 1'b1;
    repeat (2) tick();
    checks++; if (lamps !== 5'b0) $display("FAIL held_reset_lamps got=%b exp=%b", lamps, 5'b0); else passes++;
    reset = 1'b0;
    tick(); // edge k
    for (int e = 1; e <= 10; e++) begin
      tick();
      checks++;
      if (buttons !== ((e == 7) ? 5'b10001 : 5'b00000))
        $display("FAIL held_reset_latency edge=%0d got=%b exp=%b", e, buttons, (e == 7) ? 5'b10001 : 5'b00000);
      else passes++;
    end
    checks++; if (pending_count !== 3'd2) $display("FAIL held_reset_count got=%0d exp=2", pending_count); else passes++;
    raw_buttons = '0;
    repeat (10) tick();
    // Out-of-range floor: nothing serviced.
    current_floor = 3'd6; door_open = 1'b1;
    repeat (3) tick();
    checks++; if (lamps !== 5'b10001) $display("FAIL out_of_range_lamps got=%b exp=%b", lamps, 5'b10001); else passes++;
    // Top floor serviced.
    current_floor = 3'd4;
    tick();
    door_open = 1'b0;
    checks++; if (lamps !== 5'b00001) $display("FAIL top_floor_lamps got=%b exp=%b", lamps, 5'b00001); else passes++;
    checks++; if (pending_count !== 3'd1) $display("FAIL top_floor_count got=%0d exp=1", pending_count); else passes++;
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_repress_and_service();
    test_press_during_service();
    test_held_through_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
